// File: rtl/cursor_select_ctrl.sv
// Column cursor and drop selector: synchronized buttons, stepping that skips full
// columns, hold-to-repeat movement, and a one-shot confirm handshake.
module cursor_select_ctrl #(
   parameter int NUM_COLS     = 7,
   parameter int COL_W        = $clog2(NUM_COLS),
   parameter int SYNC_STAGES  = 2,
   parameter int WRAP         = 1,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                playerMoveLeft,
   input  logic                playerMoveRight,
   input  logic                playerMoveConfirm,
   input  logic [NUM_COLS-1:0] colFull,
   output logic [COL_W-1:0]    columnPosition,
   output logic [COL_W-1:0]    columnSelect,
   output logic                confirmMove,
   output logic                noMoves
);

   // state   | meaning
   // IDLE    | waiting for a fresh button edge
   // MOVING  | one direction held, auto-repeat timer running
   // CONFIRM | confirm held, waiting for its release
   typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, CONFIRM = 2'd2} state_t;

   localparam int BTN     = 3;
   localparam int FILL_W  = $clog2(SYNC_STAGES + 1);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

   logic [BTN-1:0][SYNC_STAGES-1:0] syncChain;
   logic [BTN-1:0]    btnRaw, btnSync, btnPrev, btnArmed, btnRise;
   logic [FILL_W-1:0] fillCnt;
   logic              fillDone;
   logic              syncL, syncR, syncC, riseL, riseR, riseC;
   logic              moveEdgeL, moveEdgeR, heldDir;

   state_t            state, stateNext;
   logic              moveDir, moveDirNext;
   logic [CNT_W-1:0]  repCnt, repCntNext;
   logic              stepReq, stepDir, confirmTake, accept;
   logic [COL_W:0]    stepHit, relocHit;

   assign btnRaw = {playerMoveConfirm, playerMoveRight, playerMoveLeft};

   always_comb begin
      for (int b = 0; b < BTN; b++) begin
         btnSync[b] = syncChain[b][SYNC_STAGES-1];
      end
   end

   // After reset the chain holds zeros, not real samples; a button only arms once a
   // genuine low sample has reached the last stage, so a button held through reset
   // is ignored until released and pressed again.
   assign fillDone = (fillCnt == FILL_W'(SYNC_STAGES));
   assign btnRise  = btnSync & ~btnPrev & btnArmed;

   assign syncL = btnSync[0];
   assign syncR = btnSync[1];
   assign syncC = btnSync[2];
   assign riseL = btnRise[0];
   assign riseR = btnRise[1];
   assign riseC = btnRise[2];

   assign moveEdgeL = riseL & ~syncR;
   assign moveEdgeR = riseR & ~syncL;
   assign heldDir   = moveDir ? (syncR & ~syncL) : (syncL & ~syncR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncChain <= '0;
         btnPrev   <= '0;
         btnArmed  <= '0;
         fillCnt   <= '0;
      end else begin
         for (int b = 0; b < BTN; b++) begin
            syncChain[b] <= {syncChain[b][SYNC_STAGES-2:0], btnRaw[b]};
         end
         btnPrev  <= btnSync;
         btnArmed <= btnArmed | ({BTN{fillDone}} & ~btnSync);
         if (!fillDone) begin
            fillCnt <= fillCnt + FILL_W'(1);
         end
      end
   end

   // Returns {found, column}: nearest non-full column from pos in the given direction.
   // Scanning from far to near lets the nearest hit overwrite farther ones.
   function automatic logic [COL_W:0] findCol(input logic [COL_W-1:0]    pos,
                                              input logic                goRight,
                                              input logic                allowWrap,
                                              input logic [NUM_COLS-1:0] full);
      logic [COL_W:0]   res;
      logic [COL_W-1:0] idx;
      logic             inRange;
      int               cand;
      res = '0;
      for (int d = NUM_COLS - 1; d >= 1; d--) begin
         cand    = goRight ? int'(pos) + d : int'(pos) - d;
         inRange = (cand >= 0) && (cand < NUM_COLS);
         if (cand >= NUM_COLS) begin
            cand = cand - NUM_COLS;
         end else if (cand < 0) begin
            cand = cand + NUM_COLS;
         end
         idx = COL_W'(cand);
         if ((inRange || allowWrap) && !full[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign stepHit  = findCol(columnPosition, stepDir, WRAP != 0, colFull);
   assign relocHit = findCol(columnPosition, 1'b1, 1'b1, colFull);
   assign accept   = confirmTake & ~colFull[columnPosition] & ~noMoves;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         moveDir <= 1'b0;
         repCnt  <= '0;
      end else begin
         state   <= stateNext;
         moveDir <= moveDirNext;
         repCnt  <= repCntNext;
      end
   end

   always_comb begin
      stateNext   = state;
      moveDirNext = moveDir;
      repCntNext  = repCnt;
      stepReq     = 1'b0;
      stepDir     = moveDir;
      confirmTake = 1'b0;
      case (state)
         IDLE, MOVING: begin
            if (riseC) begin
               stateNext   = CONFIRM;
               repCntNext  = '0;
               confirmTake = 1'b1;
            end else if (moveEdgeL || moveEdgeR) begin
               stateNext   = MOVING;
               stepReq     = 1'b1;
               stepDir     = moveEdgeR;
               moveDirNext = moveEdgeR;
               repCntNext  = DELAY_LOAD;
            end else if (state == MOVING) begin
               if (heldDir) begin
                  if (repCnt == '0) begin
                     stepReq    = 1'b1;
                     repCntNext = RATE_LOAD;
                  end else begin
                     repCntNext = repCnt - CNT_W'(1);
                  end
               end else begin
                  stateNext  = IDLE;
                  repCntNext = '0;
               end
            end
         end
         CONFIRM: begin
            if (!syncC) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext  = IDLE;
            repCntNext = '0;
         end
      endcase
   end

   // A successful step wins; otherwise a cursor parked on a full column slides right.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         columnPosition <= '0;
         columnSelect   <= '0;
         confirmMove    <= 1'b0;
         noMoves        <= 1'b0;
      end else begin
         confirmMove <= accept;
         noMoves     <= &colFull;
         if (accept) begin
            columnSelect <= columnPosition;
         end
         if (stepReq && !noMoves && stepHit[COL_W]) begin
            columnPosition <= stepHit[COL_W-1:0];
         end else if (colFull[columnPosition] && !noMoves && relocHit[COL_W]) begin
            columnPosition <= relocHit[COL_W-1:0];
         end
      end
   end

endmodule
